// File: rtl/seq_mul_div.sv
// Sequential unsigned multiplier / restoring divider.
// One iteration per clock, WIDTH iterations per operation.
module seq_mul_div #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic [WIDTH-1:0] RESULT_LO,
  output logic             DIV_BY_ZERO
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic               mode_r;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               last;
  logic               dbz_start;

  assign dbz_start = START && MODE && (B == '0);
  assign last      = (cnt == CW'(1));

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    trial = acc[2*WIDTH-1:WIDTH-1];
    diff  = trial - {1'b0, opnd};
    if (!mode_r) begin
      if (acc[0])
        acc_nxt = {sum, acc[WIDTH-1:1]};
      else
        acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
    end else begin
      if (diff[WIDTH])
        acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        if (START)
          state_nxt = dbz_start ? FIN : CALC;
      end
      CALC: begin
        BUSY = 1'b1;
        if (last)
          state_nxt = FIN;
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt         <= '0;
      mode_r      <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
      RESULT_HI   <= '0;
      RESULT_LO   <= '0;
      DIV_BY_ZERO <= 1'b0;
    end else if (state == IDLE) begin
      if (START) begin
        mode_r <= MODE;
        cnt    <= CW'(WIDTH);
        opnd   <= MODE ? B : A;
        acc    <= {{WIDTH{1'b0}}, (MODE ? A : B)};
        if (dbz_start) begin
          RESULT_HI   <= A;
          RESULT_LO   <= '1;
          DIV_BY_ZERO <= 1'b1;
        end
      end
    end else if (state == CALC) begin
      acc <= acc_nxt;
      cnt <= cnt - CW'(1);
      if (last) begin
        RESULT_HI   <= acc_nxt[2*WIDTH-1:WIDTH];
        RESULT_LO   <= acc_nxt[WIDTH-1:0];
        DIV_BY_ZERO <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_div.sv
// Directed self-checking bench for seq_mul_div at WIDTH=8.
// Inputs driven and outputs sampled on the falling edge.
module tb_seq_mul_div;

  logic       CLK;
  logic       RST;
  logic       START;
  logic       MODE;
  logic [7:0] A;
  logic [7:0] B;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RESULT_HI;
  logic [7:0] RESULT_LO;
  logic       DIV_BY_ZERO;

  int total = 0;
  int passed = 0;

  seq_mul_div #(.WIDTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .MODE(MODE),
    .A(A),
    .B(B),
    .BUSY(BUSY),
    .DONE(DONE),
    .RESULT_HI(RESULT_HI),
    .RESULT_LO(RESULT_LO),
    .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // lat = cycles after the accepting edge until DONE is seen (bounded)
  task automatic run_op(input logic m, input logic [7:0] a,
                        input logic [7:0] b,
                        output int lat, output int bsy);
    @(negedge CLK);
    MODE = m; A = a; B = b; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    lat = 0;
    bsy = 0;
    while (!DONE && lat < 40) begin
      if (BUSY) bsy++;
      lat++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    RST = 1'b0; START = 1'b1; MODE = 1'b0; A = 8'd13; B = 8'd11;
    repeat (2) @(negedge CLK);
    total++;
    if ({BUSY, DONE, DIV_BY_ZERO} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {BUSY, DONE, DIV_BY_ZERO});
    else passed++;
    total++;
    if ({RESULT_HI, RESULT_LO} !== 16'h0000)
      $display("FAIL reset_result got %h want 0000", {RESULT_HI, RESULT_LO});
    else passed++;
    START = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    total++;
    if (BUSY !== 1'b0)
      $display("FAIL reset_start_ignored busy got %b want 0", BUSY);
    else passed++;
  endtask

  task automatic test_mul_basic;
    int lat, bsy;
    run_op(1'b0, 8'd13, 8'd11, lat, bsy);
    total++;
    if (lat !== 8) $display("FAIL mul_latency got %0d want 8", lat);
    else passed++;
    total++;
    if (bsy !== 8) $display("FAIL mul_busy_cycles got %0d want 8", bsy);
    else passed++;
    total++;
    if ({RESULT_HI, RESULT_LO} !== 16'h008F)
      $display("FAIL mul_13x11 got %h want 008f", {RESULT_HI, RESULT_LO});
    else passed++;
    total++;
    if (DIV_BY_ZERO !== 1'b0)
      $display("FAIL mul_dbz got %b want 0", DIV_BY_ZERO);
    else passed++;
    @(negedge CLK);
    total++;
    if ({DONE, BUSY} !== 2'b00)
      $display("FAIL done_pulse got %b want 00", {DONE, BUSY});
    else passed++;
    total++;
    if ({RESULT_HI, RESULT_LO} !== 16'h008F)
      $display("FAIL mul_hold got %h want 008f", {RESULT_HI, RESULT_LO});
    else passed++;
  endtask

  task automatic test_mul_edges;
    int lat, bsy;
    run_op(1'b0, 8'd255, 8'd255, lat, bsy);
    total++;
    if ({RESULT_HI, RESULT_LO} !== 16'hFE01 || lat !== 8)
      $display("FAIL mul_255x255 got %h lat %0d want fe01 lat 8",
               {RESULT_HI, RESULT_LO}, lat);
    else passed++;
    run_op(1'b0, 8'd0, 8'd200, lat, bsy);
    total++;
    if ({RESULT_HI, RESULT_LO} !== 16'h0000 || lat !== 8)
      $display("FAIL mul_0x200 got %h lat %0d want 0000 lat 8",
               {RESULT_HI, RESULT_LO}, lat);
    else passed++;
  endtask

  task automatic test_div;
    int lat, bsy;
    run_op(1'b1, 8'd200, 8'd7, lat, bsy);
    total++;
    if ({RESULT_HI, RESULT_LO, DIV_BY_ZERO} !== {8'h04, 8'h1C, 1'b0} || lat !== 8)
      $display("FAIL div_200_7 got %h/%h/%b lat %0d want 04/1c/0 lat 8",
               RESULT_HI, RESULT_LO, DIV_BY_ZERO, lat);
    else passed++;
    run_op(1'b1, 8'd5, 8'd9, lat, bsy);
    total++;
    if ({RESULT_HI, RESULT_LO} !== 16'h0500)
      $display("FAIL div_5_9 got %h/%h want 05/00", RESULT_HI, RESULT_LO);
    else passed++;
  endtask

  task automatic test_div_zero;
    int lat, bsy;
    run_op(1'b1, 8'd50, 8'd0, lat, bsy);
    total++;
    if (lat !== 0 || bsy !== 0)
      $display("FAIL dbz_latency got %0d busy %0d want 0 busy 0", lat, bsy);
    else passed++;
    total++;
    if ({RESULT_HI, RESULT_LO, DIV_BY_ZERO} !== {8'h32, 8'hFF, 1'b1})
      $display("FAIL dbz_result got %h/%h/%b want 32/ff/1",
               RESULT_HI, RESULT_LO, DIV_BY_ZERO);
    else passed++;
    @(negedge CLK);
    total++;
    if (DIV_BY_ZERO !== 1'b1 || DONE !== 1'b0)
      $display("FAIL dbz_hold got dbz %b done %b want 1 0", DIV_BY_ZERO, DONE);
    else passed++;
    run_op(1'b1, 8'd200, 8'd7, lat, bsy);
    total++;
    if ({RESULT_HI, RESULT_LO, DIV_BY_ZERO} !== {8'h04, 8'h1C, 1'b0})
      $display("FAIL dbz_clear got %h/%h/%b want 04/1c/0",
               RESULT_HI, RESULT_LO, DIV_BY_ZERO);
    else passed++;
  endtask

  // previous results are 04/1c from the last divide
  task automatic test_ignore_start;
    int k;
    @(negedge CLK);
    MODE = 1'b0; A = 8'd13; B = 8'd11; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    k = 0;
    while (!DONE && k < 40) begin
      if (k == 3) begin
        total++;
        if ({RESULT_HI, RESULT_LO} !== 16'h041C)
          $display("FAIL calc_shows_prev got %h want 041c",
                   {RESULT_HI, RESULT_LO});
        else passed++;
        START = 1'b1; MODE = 1'b1; A = 8'd1; B = 8'd1;
      end else begin
        START = 1'b0;
      end
      k++;
      @(negedge CLK);
    end
    START = 1'b0;
    total++;
    if ({RESULT_HI, RESULT_LO} !== 16'h008F || k !== 8)
      $display("FAIL ignore_start got %h lat %0d want 008f lat 8",
               {RESULT_HI, RESULT_LO}, k);
    else passed++;
  endtask

  task automatic test_reset_abort;
    int lat, bsy;
    bit seen;
    @(negedge CLK);
    MODE = 1'b0; A = 8'd13; B = 8'd11; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    total++;
    if ({BUSY, DONE, DIV_BY_ZERO, RESULT_HI, RESULT_LO} !== 19'h0)
      $display("FAIL abort_outputs got %b %h %h want 0",
               {BUSY, DONE, DIV_BY_ZERO}, RESULT_HI, RESULT_LO);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (DONE || BUSY) seen = 1'b1;
      @(negedge CLK);
    end
    total++;
    if (seen !== 1'b0)
      $display("FAIL abort_no_done got %b want 0", seen);
    else passed++;
    run_op(1'b0, 8'd13, 8'd11, lat, bsy);
    total++;
    if ({RESULT_HI, RESULT_LO} !== 16'h008F || lat !== 8)
      $display("FAIL after_abort got %h lat %0d want 008f lat 8",
               {RESULT_HI, RESULT_LO}, lat);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int k, d1, d2;
    @(negedge CLK);
    MODE = 1'b0; A = 8'd13; B = 8'd11; START = 1'b1;
    @(negedge CLK);
    k = 0; d1 = -1; d2 = -1;
    while (d2 < 0 && k < 60) begin
      if (DONE) begin
        if (d1 < 0) d1 = k;
        else begin
          d2 = k;
          START = 1'b0;
        end
      end
      k++;
      @(negedge CLK);
    end
    START = 1'b0;
    total++;
    if (d1 < 0 || d2 < 0 || d2 - d1 !== 10)
      $display("FAIL b2b_period got %0d want 10", d2 - d1);
    else passed++;
    total++;
    if ({RESULT_HI, RESULT_LO} !== 16'h008F)
      $display("FAIL b2b_result got %h want 008f", {RESULT_HI, RESULT_LO});
    else passed++;
    repeat (2) @(negedge CLK);
    total++;
    if (BUSY !== 1'b0)
      $display("FAIL b2b_idle busy got %b want 0", BUSY);
    else passed++;
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; MODE = 1'b0; A = '0; B = '0;
    test_reset();
    test_mul_basic();
    test_mul_edges();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
